fft_input_framer: RTL and testbench
===================================

Name: fft_input_framer

Overview:
- Streaming-to-parallel input stage feeding the N-point FFT core.
- Accepts one real sample per cycle over a valid/ready handshake and assembles N samples into a frame.
- Places samples in the bit-reversed order that the decimation-in-time first butterfly stage expects (pairs 2i and 2i+1).
- Ping-pong double buffer: one frame can be collected while the previous frame is held stable on the parallel output until the consumer accepts it.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- N_POINT, 16, frame length; must be a power of two and at least 4. LOG2N = $clog2(N_POINT) is derived internally, not a port.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- s_data  input  DATA_WIDTH  input sample.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  framer can accept a sample this cycle.
- y  output  DATA_WIDTH x [N_POINT] (unpacked array)  assembled frame, same array shape as the FFT core input x.
- frame_valid  output  1  y holds a complete frame.
- frame_ready  input  1  consumer takes the frame this cycle.
- frame_count  output  8  number of frames delivered; wraps 255 -> 0.

Behaviour:
- State:
  - wr_cnt [LOG2N-1:0]: next sample index.
  - wr_sel: bank being filled.
  - rd_sel: oldest full bank.
  - bank_full[1:0]: per-bank full flag.
  - bank0 and bank1, each N_POINT x DATA_WIDTH.
- Reset (asynchronous, immediate on rst high):
  - wr_cnt=0, wr_sel=0, rd_sel=0, bank_full=2'b00, frame_count=0, all bank entries 0.
  - Outputs during reset: s_ready=0, frame_valid=0, y all zero.
  - Reset mid-frame discards the partial frame and any pending full frames.
- s_ready = !rst && !bank_full[wr_sel]. Driven from registers only; no combinational path from s_valid or frame_ready.
- Accept occurs when s_valid && s_ready:
  - bank[wr_sel][addr(wr_cnt)] <= s_data.
  - wr_cnt <= wr_cnt + 1, wrapping at N_POINT.
- On the accept with wr_cnt == N_POINT-1:
  - bank_full[wr_sel] <= 1.
  - wr_sel toggles.
  - wr_cnt wraps to 0.
- Per-bank state machine: EMPTY/FILLING (bank_full=0) -> FULL on the last accept -> EMPTY on drain.
- Output side:
  - frame_valid = bank_full[rd_sel].
  - y = bank[rd_sel], continuously.
  - y stays stable while frame_valid is high and until it is drained.
- Drain occurs when frame_valid && frame_ready:
  - bank_full[rd_sel] <= 0.
  - rd_sel toggles.
  - frame_count increments.
- Latency: last sample accepted at edge t -> frame_valid high after edge t (the next cycle). Zero bubble between frames when the consumer holds frame_ready=1.
- Simultaneous events:
  - Last-sample accept into one bank and drain of the other bank in the same cycle: both take effect.
  - When both banks are full, s_ready=0 until a drain occurs. s_ready rises the cycle after the drain.
- frame_ready while frame_valid=0: no effect.
- s_valid while s_ready=0: sample not taken. The source must hold s_data/s_valid stable until it is accepted.

Optional Feature:
- FFT_INPUT_BITREV_EN:
  - Defined: addr(k) = bit-reverse of k over LOG2N bits, so y[bitrev(k)] = k-th accepted sample.
  - Undefined: addr(k) = k (natural order). Used when an upstream block already delivers samples bit-reversed.
  - All handshakes and latencies are identical in both builds.

Test Plan:
- BITREV_EN defined; frame_ready=1; send samples 0..15 back-to-back -> frame_valid=1 one cycle after the 16th accept; y[0]=0, y[1]=8, y[2]=4, y[3]=12, y[8]=1, y[15]=15; frame_count=1 after the drain.
- BITREV_EN undefined; same stimulus -> y[k]=k for all k.
- frame_ready=0; stream 48 samples continuously -> s_ready drops after sample 32 (both banks full), frame_valid=1 with y from frame 1 held constant. Raise frame_ready for one cycle -> frame 2 is presented, s_ready=1 the next cycle, and samples 33..48 land in the freed bank.
- Continuous s_valid with frame_ready=1 over 4 frames of samples 100+k -> no s_ready deassertion, four frame_valid pulses 16 cycles apart, frame_count=4.
- Assert rst after 7 samples of a frame -> s_ready=0, frame_valid=0, y all zero during reset. After release, a full 16 samples (values 50..65) are required before frame_valid, and the frame contains no stale samples.
- Random s_valid/frame_ready toggling for 1000 cycles, checked against a scoreboard -> every frame matches the expected order, no sample lost or duplicated, y never changes while frame_valid=1 && frame_ready=0.

Source files
------------

// File: rtl/fft_input_framer.sv
// Ping-pong framer that turns a one-sample-per-cycle stream into parallel frames for the FFT core.
// Build option FFT_INPUT_BITREV_EN: store samples at bit-reversed addresses (default: natural order).
module fft_input_framer #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] y [N_POINT],
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [7:0]            frame_count
);
    localparam int LOG2N = $clog2(N_POINT);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINT - 1);

    logic [LOG2N-1:0]      wr_cnt;
    logic                  wr_sel;
    logic                  rd_sel;
    logic [1:0]            bank_full;
    logic [1:0]            bank_full_next;
    logic [DATA_WIDTH-1:0] bank0 [N_POINT];
    logic [DATA_WIDTH-1:0] bank1 [N_POINT];
    logic [LOG2N-1:0]      wr_addr;
    logic                  accept;
    logic                  drain;
    logic                  last_accept;

    function automatic logic [LOG2N-1:0] addr_of(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] a;
`ifdef FFT_INPUT_BITREV_EN
        for (int i = 0; i < LOG2N; i++) begin
            a[i] = k[LOG2N-1-i];
        end
`else
        a = k;
`endif
        return a;
    endfunction

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Both ready signals depend only on registers (and rst), never on the partner's valid.
    assign s_ready     = !rst && !bank_full[wr_sel];
    assign frame_valid = bank_full[rd_sel];
    assign accept      = s_valid && s_ready;
    assign drain       = frame_valid && frame_ready;
    assign last_accept = accept && (wr_cnt == LAST_IDX);
    assign wr_addr     = addr_of(wr_cnt);

    // Fill and drain always target different banks, so both updates can land together.
    always_comb begin
        bank_full_next = bank_full;
        if (last_accept) begin
            bank_full_next[wr_sel] = 1'b1;
        end
        if (drain) begin
            bank_full_next[rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt      <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            bank_full   <= 2'b00;
            frame_count <= 8'd0;
        end else begin
            bank_full <= bank_full_next;
            if (accept) begin
                wr_cnt <= wr_cnt + LOG2N'(1);
            end
            if (last_accept) begin
                wr_sel <= ~wr_sel;
            end
            if (drain) begin
                rd_sel      <= ~rd_sel;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_POINT; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (accept) begin
            if (wr_sel) begin
                bank1[wr_addr] <= s_data;
            end else begin
                bank0[wr_addr] <= s_data;
            end
        end
    end

    // The read bank only changes on a drain, which keeps y stable while a frame waits.
    always_comb begin
        for (int i = 0; i < N_POINT; i++) begin
            y[i] = rd_sel ? bank1[i] : bank0[i];
        end
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// Self-checking bench for fft_input_framer: sample-queue model checked every cycle plus directed literals.
module tb_fft_input_framer;
    localparam int W     = 16;
    localparam int N     = 16;
    localparam int LOG2N = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] y [N];
    logic         frame_valid;
    logic         frame_ready;
    logic [7:0]   frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: every accepted, not-yet-drained sample in arrival order.
    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_fc;
    logic [W-1:0] ey [N];
    int           bad_idx;

    bit  watch_en = 0;
    int  fv_times[$];
    int  sr_drops = 0;
    bit  stream_done;
    bit  rand_stop;

    fft_input_framer #(.DATA_WIDTH(W), .N_POINT(N)) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .y(y),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_count(frame_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic int tb_addr(input int k);
`ifdef FFT_INPUT_BITREV_EN
        int r = 0;
        for (int b = 0; b < LOG2N; b++) r = r * 2 + ((k >> b) & 1);
        return r;
`else
        return k;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_sample(input logic [W-1:0] v);
        int  waitc = 0;
        logic took = 1'b0;
        s_data  = v;
        s_valid = 1'b1;
        while (!took && waitc < 200) begin
            @(negedge clk);
            took = s_ready;
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!took) check("push_timeout", took, 1);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_fc = 8'd0;
            check("rst_s_ready", s_ready, 0);
            check("rst_frame_valid", frame_valid, 0);
            check("rst_frame_count", frame_count, 0);
        end else begin
            int  full_frames;
            bit  e_fv;
            bit  e_sr;
            full_frames = exp_q.size() / N;
            e_fv = full_frames > 0;
            e_sr = full_frames < 2;
            check("s_ready", s_ready, e_sr);
            check("frame_valid", frame_valid, e_fv);
            check("frame_count", frame_count, exp_fc);
            if (e_fv) begin
                for (int j = 0; j < N; j++) ey[tb_addr(j)] = exp_q[j];
                bad_idx = -1;
                for (int k = 0; k < N; k++)
                    if (y[k] !== ey[k] && bad_idx < 0) bad_idx = k;
                if (bad_idx < 0) check("frame_y", y[0], ey[0]);
                else check($sformatf("frame_y[%0d]", bad_idx), y[bad_idx], ey[bad_idx]);
            end
            // advance the model to what the coming rising edge must do
            if (s_valid && e_sr) exp_q.push_back(s_data);
            if (e_fv && frame_ready) begin
                repeat (N) void'(exp_q.pop_front());
                exp_fc = exp_fc + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (watch_en) begin
            if (frame_valid) fv_times.push_back(cyc);
            if (!s_ready) sr_drops++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int nz;
        bit ok_sp;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        frame_ready = 1'b0;
        idle(3);
        rst = 1'b0;

        // T1: one frame 0..15 with consumer ready
        frame_ready = 1'b1;
        for (int k = 0; k < N; k++) push_sample(W'(k));
        @(negedge clk);
        check("t1_frame_valid", frame_valid, 1);
        check("t1_y0", y[0], 0);
`ifdef FFT_INPUT_BITREV_EN
        check("t1_y1", y[1], 8);
        check("t1_y2", y[2], 4);
        check("t1_y3", y[3], 12);
        check("t1_y8", y[8], 1);
`else
        check("t1_y1", y[1], 1);
        check("t1_y2", y[2], 2);
        check("t1_y3", y[3], 3);
        check("t1_y8", y[8], 8);
`endif
        check("t1_y15", y[15], 15);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_frame_count", frame_count, 1);
        check("t1_valid_after_drain", frame_valid, 0);

        // T2: backpressure, 48 samples with consumer stalled
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        stream_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 48; k++) push_sample(W'(200 + k));
                stream_done = 1'b1;
            end
        join_none
        idle(40);
        @(negedge clk);
        check("t2_s_ready_both_full", s_ready, 0);
        check("t2_frame_valid", frame_valid, 1);
        check("t2_f1_y0", y[0], 200);
        check("t2_f1_y15", y[15], 215);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        @(negedge clk);
        check("t2_f2_valid", frame_valid, 1);
        check("t2_f2_y0", y[0], 216);
        check("t2_s_ready_after_drain", s_ready, 1);
        for (int t = 0; t < 100 && !stream_done; t++) idle(1);
        check("t2_stream_done", stream_done, 1);
        @(negedge clk);
        check("t2_full_again", s_ready, 0);
        check("t2_f2_y15", y[15], 231);
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        idle(1);
        @(negedge clk);
        check("t2_f3_y0", y[0], 232);
        check("t2_f3_y15", y[15], 247);
        idle(1);
        @(negedge clk);
        check("t2_frame_count", frame_count, 4);
        check("t2_drained", frame_valid, 0);

        // T3: four back-to-back frames, consumer always ready
        @(posedge clk);
        #1;
        fv_times.delete();
        sr_drops = 0;
        watch_en = 1'b1;
        for (int k = 0; k < 4 * N; k++) push_sample(W'(100 + k));
        idle(3);
        watch_en = 1'b0;
        check("t3_fv_pulses", fv_times.size(), 4);
        ok_sp = 1'b1;
        for (int i = 1; i < fv_times.size(); i++)
            if (fv_times[i] - fv_times[i-1] != 16) ok_sp = 1'b0;
        check("t3_fv_spacing", ok_sp, 1);
        check("t3_s_ready_drops", sr_drops, 0);
        @(negedge clk);
        check("t3_frame_count", frame_count, 8);

        // T4: reset after 7 samples of a frame
        @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) push_sample(W'(300 + k));
        rst = 1'b1;
        @(negedge clk);
        nz = 0;
        for (int k = 0; k < N; k++) if (y[k] !== '0) nz++;
        check("t4_rst_y_zero", nz, 0);
        check("t4_rst_s_ready", s_ready, 0);
        check("t4_rst_frame_valid", frame_valid, 0);
        idle(2);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) push_sample(W'(50 + k));
        @(negedge clk);
        check("t4_no_early_frame", frame_valid, 0);
        @(posedge clk);
        #1;
        push_sample(W'(65));
        @(negedge clk);
        check("t4_frame_valid", frame_valid, 1);
        check("t4_y0", y[0], 50);
        check("t4_y15", y[15], 65);
`ifdef FFT_INPUT_BITREV_EN
        check("t4_y10", y[10], 55);
`else
        check("t4_y5", y[5], 55);
`endif
        idle(1);
        @(negedge clk);
        check("t4_frame_count", frame_count, 1);

        // T5: random valid/ready toggling for 1000 cycles
        rand_stop = 1'b0;
        fork
            begin
                repeat (1000) begin
                    @(posedge clk);
                    #1;
                    frame_ready = 1'($urandom_range(0, 1));
                end
                rand_stop = 1'b1;
            end
            begin
                while (!rand_stop) begin
                    idle($urandom_range(0, 2));
                    push_sample(W'($urandom_range(0, 16'hffff)));
                end
            end
        join
        frame_ready = 1'b1;
        idle(5);
        @(negedge clk);
        check("t5_all_drained", frame_valid, 0);
        frame_ready = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
